// File: rtl/div_iter.sv
// rtl/div_iter.sv - iterative 32-bit radix-2 restoring divider with divide-by-zero and annul handling
module div_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {S_IDLE, S_BYZERO, S_BUSY, S_DONE} state_t;

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic [64:0] r_work;
    logic [31:0] r_divisor;
    logic [31:0] r_dividend;
    logic        r_neg1;
    logic        r_neg2;

    logic        w_op1_neg;
    logic        w_op2_neg;
    logic [31:0] w_op1_mag;
    logic [31:0] w_op2_mag;
    logic [64:0] w_shift;
    logic [33:0] w_trial;
    logic [64:0] w_next_work;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;

    assign w_op1_neg = signed_div_i & opdata1_i[31];
    assign w_op2_neg = signed_div_i & opdata2_i[31];
    assign w_op1_mag = w_op1_neg ? (32'd0 - opdata1_i) : opdata1_i;
    assign w_op2_mag = w_op2_neg ? (32'd0 - opdata2_i) : opdata2_i;

    // Partial remainder stays below 2*divisor after the shift, so 34 bits hold the trial and its borrow.
    assign w_shift     = r_work << 1;
    assign w_trial     = {1'b0, w_shift[64:32]} - {2'b00, r_divisor};
    assign w_next_work = w_trial[33] ? w_shift : {w_trial[32:0], w_shift[31:1], 1'b1};

    assign w_quo     = w_next_work[31:0];
    assign w_rem     = w_next_work[63:32];
    assign w_quo_fix = (r_neg1 ^ r_neg2) ? (32'd0 - w_quo) : w_quo;
    assign w_rem_fix = r_neg1 ? (32'd0 - w_rem) : w_rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 6'd0;
            r_work     <= 65'd0;
            r_divisor  <= 32'd0;
            r_dividend <= 32'd0;
            r_neg1     <= 1'b0;
            r_neg2     <= 1'b0;
            result_o   <= 64'd0;
            ready_o    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    ready_o <= 1'b0;
                    if (start_i && !annul_i) begin
                        if (opdata2_i == 32'd0) begin
                            r_dividend <= opdata1_i;
                            r_state    <= S_BYZERO;
                        end else begin
                            r_work    <= {33'd0, w_op1_mag};
                            r_divisor <= w_op2_mag;
                            r_neg1    <= w_op1_neg;
                            r_neg2    <= w_op2_neg;
                            r_cnt     <= 6'd0;
                            r_state   <= S_BUSY;
                        end
                    end
                end
                S_BYZERO: begin
                    result_o <= {r_dividend, 32'hFFFF_FFFF};
                    ready_o  <= 1'b1;
                    r_state  <= S_DONE;
                end
                S_BUSY: begin
                    if (annul_i) begin
                        ready_o <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_work <= w_next_work;
                        r_cnt  <= r_cnt + 6'd1;
                        if (r_cnt == 6'd31) begin
                            result_o <= {w_rem_fix, w_quo_fix};
                            ready_o  <= 1'b1;
                            r_state  <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (annul_i || !start_i) begin
                        ready_o <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    ready_o <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// tb/tb_div_iter.sv - self-checking bench for div_iter: vector table, random ops vs arithmetic model, corner sequences
module tb_div_iter;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int checks;
    int failures;

    div_iter dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        logic [63:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        longint sa, sb, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa - q * sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Called #1 after a rising edge; returns #1 after the edge that leaves the block idle again.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                          input logic [63:0] exp, input int hold, input string name);
        int lat;
        int exp_lat;
        logic stable;
        exp_lat = (b == 32'd0) ? 2 : 33;
        opdata1_i    = a;
        opdata2_i    = b;
        signed_div_i = sgn;
        start_i      = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!ready_o && lat < 100);
        chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({name, "_result"}, result_o, exp);
        stable = 1'b1;
        repeat (hold) begin
            @(posedge clk); #1;
            if (ready_o !== 1'b1 || result_o !== exp) stable = 1'b0;
        end
        if (hold > 0) chk({name, "_hold_stable"}, 64'(stable), 64'd1);
        start_i = 1'b0;
        @(posedge clk); #1;
        chk({name, "_ready_drop"}, 64'(ready_o), 64'd0);
        chk({name, "_result_kept"}, result_o, exp);
    endtask

    vec_t vecs[10];
    logic [63:0] last_exp;

    initial begin
        logic [31:0] ra, rb;
        logic        rs;
        logic        low;

        checks   = 0;
        failures = 0;
        rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
        opdata1_i = 32'd0; opdata2_i = 32'd0;

        vecs[0] = '{32'd100,        32'd7,          1'b0, {32'd2,          32'd14}};
        vecs[1] = '{32'hFFFF_FFF9,  32'd2,          1'b1, {32'hFFFF_FFFF,  32'hFFFF_FFFD}};
        vecs[2] = '{32'd7,          32'hFFFF_FFFE,  1'b1, {32'h0000_0001,  32'hFFFF_FFFD}};
        vecs[3] = '{32'hFFFF_FFF9,  32'd2,          1'b0, {32'd1,          32'h7FFF_FFFC}};
        vecs[4] = '{32'd5,          32'd0,          1'b0, {32'd5,          32'hFFFF_FFFF}};
        vecs[5] = '{32'd5,          32'd0,          1'b1, {32'd5,          32'hFFFF_FFFF}};
        vecs[6] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, {32'd0,          32'h8000_0000}};
        vecs[7] = '{32'hFFFF_FFFF,  32'd1,          1'b0, {32'd0,          32'hFFFF_FFFF}};
        vecs[8] = '{32'd3,          32'hFFFF_FFFF,  1'b0, {32'd3,          32'd0}};
        vecs[9] = '{32'hFFFF_FF9C,  32'd7,          1'b1, {32'hFFFF_FFFE,  32'hFFFF_FFF2}};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", 64'(ready_o), 64'd0);
        chk("reset_result", result_o, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].exp, 0, $sformatf("vec%0d", i));

        last_exp = 64'd0;
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0: rb = $urandom;
                1: rb = $urandom_range(1, 15);
                2: rb = 32'd0 - $urandom_range(1, 15);
                3: rb = $urandom >> $urandom_range(0, 31);
                default: rb = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'h8000_0000;
            endcase
            last_exp = ref_div(ra, rb, rs);
            run_op(ra, rb, rs, last_exp, 0, $sformatf("rand%0d", i));
        end

        opdata1_i = 32'd1000; opdata2_i = 32'd3; signed_div_i = 1'b0; start_i = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        annul_i = 1'b1;
        start_i = 1'b0;
        @(posedge clk); #1;
        annul_i = 1'b0;
        low = 1'b1;
        repeat (30) begin
            if (ready_o !== 1'b0) low = 1'b0;
            @(posedge clk); #1;
        end
        chk("annul_ready_low", 64'(low), 64'd1);
        chk("annul_result_kept", result_o, last_exp);
        run_op(32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 0, "after_annul");

        opdata1_i = 32'd1000; opdata2_i = 32'd7; signed_div_i = 1'b0; start_i = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        rst = 1'b1;
        start_i = 1'b0;
        @(posedge clk); #1;
        chk("midbusy_rst_ready", 64'(ready_o), 64'd0);
        chk("midbusy_rst_result", result_o, 64'd0);
        rst = 1'b0;
        run_op(32'd10, 32'd4, 1'b0, {32'd2, 32'd2}, 0, "after_rst");
        run_op(32'd100, 32'd7, 1'b1, {32'd2, 32'd14}, 5, "done_hold");
        run_op(32'd0, 32'd0, 1'b1, {32'd0, 32'hFFFF_FFFF}, 0, "zero_by_zero");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
